// File: rtl/bingo_link_pkg.sv
// rtl/bingo_link_pkg.sv - shared encodings and beat helpers for the two-board Bingo link
package bingo_link_pkg;

  localparam int MSG_TYPE_W   = 3;
  localparam int NUM_W        = 5;
  localparam int BEAT_W       = 6;
  localparam int BEAT_HDR_BIT = 5;

  typedef enum logic [MSG_TYPE_W-1:0] {
    MSG_NONE   = 3'd0,
    MSG_NUMBER = 3'd1,
    MSG_START  = 3'd2,
    MSG_BINGO  = 3'd3,
    MSG_WIN    = 3'd4,
    MSG_LOSE   = 3'd5,
    MSG_SYNC   = 3'd6,
    MSG_RESET  = 3'd7
  } msg_type_e;

  typedef enum logic [1:0] {
    S_DRAIN = 2'd0,
    S_IDLE  = 2'd1,
    S_ACK   = 2'd2
  } rx_state_e;

  function automatic logic is_header(input logic [BEAT_W-1:0] beat);
    return beat[BEAT_HDR_BIT];
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - STAGES-deep single-bit synchroniser, clears to 0 on reset
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d = {sync_q[STAGES-2:0], d_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/interboard_rx_link.sv
// rtl/interboard_rx_link.sv - 4-phase receive link assembling header+payload frames
// Optional payload timeout with frame_err enabled by INTERBOARD_RX_TIMEOUT_EN.
module interboard_rx_link
  import bingo_link_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Request_in,
  input  logic [BEAT_W-1:0]     inter_data_in,
  output logic                  Ack_out,
  output logic                  interboard_en,
  output logic [MSG_TYPE_W-1:0] interboard_msg_type,
  output logic [NUM_W-1:0]      interboard_number,
  output logic                  interboard_rst,
  output logic                  frame_err
);

  localparam int                FILL_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

  logic req_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (Request_in),
    .q_o (req_s)
  );

  rx_state_e             state_q, state_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  ack_q, ack_d;
  logic                  expecting_q, expecting_d;
  logic [MSG_TYPE_W-1:0] type_hold_q, type_hold_d;
  logic [MSG_TYPE_W-1:0] msg_type_q, msg_type_d;
  logic [NUM_W-1:0]      number_q, number_d;
  logic                  en_q, en_d;
  logic                  rst_pulse_q, rst_pulse_d;
  logic                  sample;
  logic                  hdr_accept;
  logic                  pay_accept;

`ifdef INTERBOARD_RX_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    expecting_d = expecting_q;
    type_hold_d = type_hold_q;
    msg_type_d  = msg_type_q;
    number_d    = number_q;
    en_d        = 1'b0;
    rst_pulse_d = 1'b0;
    sample      = 1'b0;

    // The synchroniser is zero right after reset, so a held request only becomes
    // visible once it has refilled; DRAIN waits for that before trusting req_s==0.
    if (fill_q != FILL_DONE) fill_d = fill_q + 1'b1;

    unique case (state_q)
      S_DRAIN: if (fill_q == FILL_DONE && !req_s) state_d = S_IDLE;
      S_IDLE: begin
        if (req_s) begin
          sample  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   if (!req_s) state_d = S_IDLE;
      default: state_d = S_DRAIN;
    endcase

    hdr_accept = sample && is_header(inter_data_in);
    pay_accept = sample && !is_header(inter_data_in) && expecting_q;

    if (hdr_accept) begin
      type_hold_d = inter_data_in[MSG_TYPE_W-1:0];
      expecting_d = 1'b1;
    end
    if (pay_accept) begin
      msg_type_d  = type_hold_q;
      number_d    = inter_data_in[NUM_W-1:0];
      en_d        = 1'b1;
      rst_pulse_d = (type_hold_q == MSG_RESET);
      expecting_d = 1'b0;
    end

`ifdef INTERBOARD_RX_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (hdr_accept) begin
      cnt_d = '0;
    end else if (expecting_q) begin
      if (cnt_q == CNT_LAST) begin
        if (!pay_accept) begin
          expecting_d = 1'b0;
          err_d       = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif

    ack_d = (state_d == S_ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_DRAIN;
      fill_q      <= '0;
      ack_q       <= 1'b0;
      expecting_q <= 1'b0;
      type_hold_q <= '0;
      msg_type_q  <= '0;
      number_q    <= '0;
      en_q        <= 1'b0;
      rst_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      ack_q       <= ack_d;
      expecting_q <= expecting_d;
      type_hold_q <= type_hold_d;
      msg_type_q  <= msg_type_d;
      number_q    <= number_d;
      en_q        <= en_d;
      rst_pulse_q <= rst_pulse_d;
    end
  end

`ifdef INTERBOARD_RX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign Ack_out             = ack_q;
  assign interboard_en       = en_q;
  assign interboard_msg_type = msg_type_q;
  assign interboard_number   = number_q;
  assign interboard_rst      = rst_pulse_q;

endmodule

// File: tb/tb_interboard_rx_link.sv
// tb/tb_interboard_rx_link.sv - scoreboard bench for interboard_rx_link
module tb_interboard_rx_link;
  import bingo_link_pkg::*;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Request_in = 1'b0;
  logic [5:0] inter_data_in = '0;
  logic       Ack_out;
  logic       interboard_en;
  logic [2:0] interboard_msg_type;
  logic [4:0] interboard_number;
  logic       interboard_rst;
  logic       frame_err;

  always #5 clk = ~clk;

  interboard_rx_link #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Request_in          (Request_in),
    .inter_data_in       (inter_data_in),
    .Ack_out             (Ack_out),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .interboard_number   (interboard_number),
    .interboard_rst      (interboard_rst),
    .frame_err           (frame_err)
  );

  typedef struct packed {
    logic [2:0] t;
    logic [4:0] n;
    logic       r;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   en_count  = 0;
  int   ack_rises = 0;
  int   err_count = 0;
  logic ack_prev  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (interboard_rst) begin
        checks++;
        if (!interboard_en) begin
          errors++;
          $display("FAIL rst_without_en: interboard_rst=1 en=%0b, required en=1", interboard_en);
        end
      end
      if (interboard_en) begin
        en_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_en: type=%0d number=%0d rst=%0b, required no pulse",
                   interboard_msg_type, interboard_number, interboard_rst);
        end else begin
          e = exp_q.pop_front();
          if ({interboard_msg_type, interboard_number, interboard_rst} !== e) begin
            errors++;
            $display("FAIL frame: type=%0d number=%0d rst=%0b, required type=%0d number=%0d rst=%0b",
                     interboard_msg_type, interboard_number, interboard_rst, e.t, e.n, e.r);
          end
        end
      end
      if (Ack_out && !ack_prev) ack_rises++;
      if (frame_err) err_count++;
    end
    ack_prev = Ack_out;
  end

  task automatic send_beat(input logic [5:0] beat);
    int n;
    int rises0;
    rises0 = ack_rises;
    @(negedge clk);
    inter_data_in = beat;
    Request_in    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!Ack_out && n < 20);
    checks++;
    if (n != SYNC + 1 || !Ack_out) begin
      errors++;
      $display("FAIL ack_latency beat=%b: %0d cycles ack=%0b, required %0d cycles ack=1", beat, n, Ack_out, SYNC + 1);
    end
    Request_in = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (Ack_out && n < 20);
    checks++;
    if (Ack_out !== 1'b0) begin
      errors++;
      $display("FAIL ack_release beat=%b: ack=%0b, required 0", beat, Ack_out);
    end
    @(negedge clk);
    checks++;
    if (ack_rises - rises0 != 1) begin
      errors++;
      $display("FAIL ack_once beat=%b: %0d ack pulses, required 1", beat, ack_rises - rises0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({Ack_out, interboard_en, interboard_msg_type, interboard_number, interboard_rst, frame_err} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%0b en=%0b type=%0d num=%0d rst=%0b err=%0b, required all 0",
               Ack_out, interboard_en, interboard_msg_type, interboard_number, interboard_rst, frame_err);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int e0;
    e0 = en_count;
    exp_q.push_back({3'd3, 5'd22, 1'b0});
    send_beat(6'b100011);
    checks++;
    if (en_count != e0) begin
      errors++;
      $display("FAIL header_no_en: %0d pulses, required 0", en_count - e0);
    end
    send_beat(6'b010110);
    checks++;
    if (en_count != e0 + 1 || interboard_msg_type !== 3'd3 || interboard_number !== 5'd22) begin
      errors++;
      $display("FAIL basic_frame: pulses=%0d type=%0d num=%0d, required 1/3/22",
               en_count - e0, interboard_msg_type, interboard_number);
    end
  endtask

  task automatic test_reset_msg();
    int e0;
    e0 = en_count;
    exp_q.push_back({3'd7, 5'd0, 1'b1});
    send_beat(6'b100111);
    send_beat(6'b000000);
    checks++;
    if (en_count != e0 + 1 || interboard_msg_type !== 3'd7 || interboard_number !== 5'd0) begin
      errors++;
      $display("FAIL reset_msg: pulses=%0d type=%0d num=%0d, required 1/7/0",
               en_count - e0, interboard_msg_type, interboard_number);
    end
  endtask

  task automatic test_orphan_payload();
    int e0;
    e0 = en_count;
    send_beat(6'b000101);
    checks++;
    if (en_count != e0 || interboard_msg_type !== 3'd7 || interboard_number !== 5'd0) begin
      errors++;
      $display("FAIL orphan_payload: pulses=%0d type=%0d num=%0d, required 0/7/0",
               en_count - e0, interboard_msg_type, interboard_number);
    end
  endtask

  task automatic test_resync();
    int e0;
    e0 = en_count;
    exp_q.push_back({3'd5, 5'd9, 1'b0});
    send_beat(6'b100010);
    send_beat(6'b100101);
    send_beat(6'b001001);
    checks++;
    if (en_count != e0 + 1 || interboard_msg_type !== 3'd5 || interboard_number !== 5'd9) begin
      errors++;
      $display("FAIL resync: pulses=%0d type=%0d num=%0d, required 1/5/9",
               en_count - e0, interboard_msg_type, interboard_number);
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    logic [2:0] t;
    logic [4:0] n;
    e0 = en_count;
    for (int i = 0; i < 4; i++) begin
      t = 3'($urandom_range(7, 0));
      n = 5'($urandom_range(31, 0));
      exp_q.push_back({t, n, (t == 3'd7)});
      send_beat({1'b1, 2'b00, t});
      send_beat({1'b0, n});
    end
    checks++;
    if (en_count != e0 + 4 || exp_q.size() != 0 || interboard_msg_type !== t || interboard_number !== n) begin
      errors++;
      $display("FAIL back_to_back: pulses=%0d pending=%0d type=%0d num=%0d, required 4/0/%0d/%0d",
               en_count - e0, exp_q.size(), interboard_msg_type, interboard_number, t, n);
    end
  endtask

  task automatic test_rst_mid_handshake();
    int   e0;
    int   r0;
    int   n;
    logic seen;
    send_beat(6'b100100);
    e0 = en_count;
    @(negedge clk);
    inter_data_in = 6'b100110;
    Request_in    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!Ack_out && n < 20);
    checks++;
    if (!Ack_out) begin
      errors++;
      $display("FAIL mid_ack: ack=%0b, required 1", Ack_out);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (Ack_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_drops_ack: ack=%0b, required 0", Ack_out);
    end
    rst = 1'b0;
    r0 = ack_rises;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (Ack_out) seen = 1'b1;
    end
    checks++;
    if (seen || ack_rises != r0 || interboard_msg_type !== 3'd0 || interboard_number !== 5'd0) begin
      errors++;
      $display("FAIL no_resample: ack_seen=%0b type=%0d num=%0d, required 0/0/0",
               seen, interboard_msg_type, interboard_number);
    end
    Request_in = 1'b0;
    repeat (5) @(negedge clk);
    send_beat(6'b001100);
    checks++;
    if (en_count != e0) begin
      errors++;
      $display("FAIL partial_discard: %0d pulses, required 0", en_count - e0);
    end
    exp_q.push_back({3'd1, 5'd2, 1'b0});
    send_beat(6'b100001);
    send_beat(6'b000010);
    checks++;
    if (en_count != e0 + 1) begin
      errors++;
      $display("FAIL after_rst_frame: %0d pulses, required 1", en_count - e0);
    end
  endtask

`ifdef INTERBOARD_RX_TIMEOUT_EN
  task automatic test_timeout();
    int e0;
    int err0;
    int n;
    e0   = en_count;
    err0 = err_count;
    @(negedge clk);
    inter_data_in = 6'b100001;
    Request_in    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!Ack_out && n < 20);
    Request_in = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_err && n < 40);
    checks++;
    if (n != TMO || !frame_err) begin
      errors++;
      $display("FAIL timeout_cycle: err at %0d err=%0b, required at %0d", n, frame_err, TMO);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: err=%0b, required 0", frame_err);
    end
    send_beat(6'b000011);
    checks++;
    if (en_count != e0 || err_count != err0 + 1) begin
      errors++;
      $display("FAIL timeout_discard: pulses=%0d errs=%0d, required 0/1", en_count - e0, err_count - err0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_reset_msg();
    test_orphan_payload();
    test_resync();
    test_back_to_back();
    test_rst_mid_handshake();
`ifdef INTERBOARD_RX_TIMEOUT_EN
    test_timeout();
`else
    checks++;
    if (err_count != 0) begin
      errors++;
      $display("FAIL frame_err_tied: %0d pulses, required 0", err_count);
    end
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_frames: %0d left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
